multicycle_ctrl: RTL and testbench



---
 rtl/rv32_ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_word_dec.sv | 83 ++++++++
 rtl/multicycle_ctrl.sv | 121 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I sequencer:
// FSM states, opcodes, mux selects and the decoded control word.
package rv32_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_JAL    = 4'd9,
    S_BRANCH = 4'd10,
    S_LUI    = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // fetch/jump/branch are PC-update qualifiers;
  // the top combines them with mem_ready and zero.
  typedef struct packed {
    logic       fetch;
    logic       jump;
    logic       branch;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_we;
    logic       reg_re;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_word_dec.sv
// Pure state -> control-word decode for the multicycle sequencer.
// Unlisted fields stay zero in every state.
module ctrl_word_dec
  import rv32_ctrl_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    unique case (state_i)
      S_FETCH: begin
        cw_o.fetch      = 1'b1;
        cw_o.adr_src    = 1'b0;
        cw_o.mem_read   = 1'b1;
        cw_o.alu_src_a  = SRCA_PC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.alu_op     = ALU_ADD;
        cw_o.result_src = RES_ALU;
      end
      S_DECODE: begin
        cw_o.reg_re    = 1'b1;
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        cw_o.adr_src    = 1'b1;
        cw_o.mem_read   = 1'b1;
        cw_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        cw_o.result_src = RES_MEM;
        cw_o.reg_we     = 1'b1;
      end
      S_MEMWR: begin
        cw_o.adr_src    = 1'b1;
        cw_o.mem_write  = 1'b1;
        cw_o.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_RS2;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_LUI: begin
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_PASSB;
      end
      S_ALUWB: begin
        cw_o.result_src = RES_ALUOUT;
        cw_o.reg_we     = 1'b1;
      end
      S_JAL: begin
        cw_o.jump       = 1'b1;
        cw_o.alu_src_a  = SRCA_OLDPC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.alu_op     = ALU_ADD;
        cw_o.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        cw_o.branch     = 1'b1;
        cw_o.alu_src_a  = SRCA_RS1;
        cw_o.alu_src_b  = SRCB_RS2;
        cw_o.alu_op     = ALU_SUB;
        cw_o.result_src = RES_ALUOUT;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the non-pipelined RV32I core:
// state register, branch decision and retired-instruction counter.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_we,
  output logic                 reg_re,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  state_e                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   illegal_q;
  logic                   retire;
  logic                   take;
  logic                   br_ok;
  ctrl_word_t             cw;

  ctrl_word_dec u_dec (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign br_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  assign take  = ((funct3 == F3_BEQ) &&  zero) ||
                 ((funct3 == F3_BNE) && !zero);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = br_ok ? S_BRANCH : S_TRAP;
          OP_JAL:    state_d = S_JAL;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_JAL:    state_d = S_ALUWB;
      S_ALUWB,
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Strobes are gated by rst_n so an asserted reset kills
  // any access at once, even though FETCH is the reset state.
  assign pc_write  = rst_n & ((cw.fetch & mem_ready) | cw.jump |
                              (cw.branch & take));
  assign ir_write  = rst_n & cw.fetch & mem_ready;
  assign mem_read  = rst_n & cw.mem_read;
  assign mem_write = rst_n & cw.mem_write;
  assign reg_we    = rst_n & cw.reg_we;
  assign reg_re    = rst_n & cw.reg_re;

  assign adr_src    = cw.adr_src;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign result_src = cw.result_src;
  assign illegal    = illegal_q;
  assign state_o    = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks R, load, store,
// branch, jal, trap and async-reset abort sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src;
  logic        mem_read, mem_write, reg_we, reg_re;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic        illegal;
  logic [3:0]  state_o;
  logic [31:0] instret;
  logic [5:0]  stb;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {pc_write, ir_write, mem_read, mem_write, reg_we, reg_re}
  assign stb = {pc_write, ir_write, mem_read,
                mem_write, reg_we, reg_re};

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal    (illegal),
    .state_o    (state_o),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [6:0] op,
                     input logic [2:0] f3,
                     input logic       z,
                     input logic       rdy);
    @(negedge clk);
    opcode    = op;
    funct3    = f3;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic st(input string tag,
                    input logic [3:0] s,
                    input logic [5:0] sb);
    chk({tag, "_state"}, 32'(state_o), 32'(s));
    chk({tag, "_stb"}, 32'(stb), 32'(sb));
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    st(tag, 4'd0, 6'b000000);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_ir"}, instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    funct3    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    st("rst", 4'd0, 6'b000000);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_ir", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type: 0,1,6,8,0
    cyc(RR, 3'd0, 1'b0, 1'b1); st("r_f", 4'd0, 6'b111000);
    cyc(RR, 3'd0, 1'b0, 1'b1); st("r_d", 4'd1, 6'b000001);
    cyc(RR, 3'd0, 1'b0, 1'b1); st("r_x", 4'd6, 6'b000000);
    chk("r_x_op", 32'(alu_op), 32'd2);
    cyc(RR, 3'd0, 1'b0, 1'b1); st("r_wb", 4'd8, 6'b000010);

    // lw with 3 wait cycles in MEMRD
    cyc(LD, 3'd2, 1'b0, 1'b1); st("lw_f", 4'd0, 6'b111000);
    chk("r_ir", instret, 32'd1);
    cyc(LD, 3'd2, 1'b0, 1'b1); st("lw_d", 4'd1, 6'b000001);
    cyc(LD, 3'd2, 1'b0, 1'b0); st("lw_a", 4'd2, 6'b000000);
    chk("lw_a_srca", 32'(alu_src_a), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(LD, 3'd2, 1'b0, 1'b0);
      st("lw_rdw", 4'd3, 6'b001000);
    end
    cyc(LD, 3'd2, 1'b0, 1'b1); st("lw_rd", 4'd3, 6'b001000);
    chk("lw_rd_adr", 32'(adr_src), 32'd1);
    cyc(LD, 3'd2, 1'b0, 1'b1); st("lw_wb", 4'd4, 6'b000010);
    chk("lw_wb_res", 32'(result_src), 32'd1);

    // sw with 2 wait cycles in MEMWR
    cyc(ST, 3'd2, 1'b0, 1'b1); st("sw_f", 4'd0, 6'b111000);
    chk("lw_ir", instret, 32'd2);
    cyc(ST, 3'd2, 1'b0, 1'b1); st("sw_d", 4'd1, 6'b000001);
    cyc(ST, 3'd2, 1'b0, 1'b0); st("sw_a", 4'd2, 6'b000000);
    cyc(ST, 3'd2, 1'b0, 1'b0); st("sw_w0", 4'd5, 6'b000100);
    cyc(ST, 3'd2, 1'b0, 1'b0); st("sw_w1", 4'd5, 6'b000100);
    cyc(ST, 3'd2, 1'b0, 1'b1); st("sw_w2", 4'd5, 6'b000100);

    // beq taken
    cyc(BR, 3'd0, 1'b1, 1'b1); st("beq1_f", 4'd0, 6'b111000);
    chk("sw_ir", instret, 32'd3);
    cyc(BR, 3'd0, 1'b1, 1'b1); st("beq1_d", 4'd1, 6'b000001);
    cyc(BR, 3'd0, 1'b1, 1'b1); st("beq1_b", 4'd10, 6'b100000);
    chk("beq1_op", 32'(alu_op), 32'd1);

    // beq not taken
    cyc(BR, 3'd0, 1'b0, 1'b1); st("beq0_f", 4'd0, 6'b111000);
    chk("beq1_ir", instret, 32'd4);
    cyc(BR, 3'd0, 1'b0, 1'b1); st("beq0_d", 4'd1, 6'b000001);
    cyc(BR, 3'd0, 1'b0, 1'b1); st("beq0_b", 4'd10, 6'b000000);

    // bne taken on zero=0
    cyc(BR, 3'd1, 1'b0, 1'b1); st("bne_f", 4'd0, 6'b111000);
    chk("beq0_ir", instret, 32'd5);
    cyc(BR, 3'd1, 1'b0, 1'b1); st("bne_d", 4'd1, 6'b000001);
    cyc(BR, 3'd1, 1'b0, 1'b1); st("bne_b", 4'd10, 6'b100000);

    // jal: 0,1,9,8,0
    cyc(JL, 3'd0, 1'b0, 1'b1); st("jal_f", 4'd0, 6'b111000);
    chk("bne_ir", instret, 32'd6);
    cyc(JL, 3'd0, 1'b0, 1'b1); st("jal_d", 4'd1, 6'b000001);
    cyc(JL, 3'd0, 1'b0, 1'b1); st("jal_j", 4'd9, 6'b100000);
    chk("jal_srca", 32'(alu_src_a), 32'd1);
    chk("jal_srcb", 32'(alu_src_b), 32'd2);
    cyc(JL, 3'd0, 1'b0, 1'b1); st("jal_wb", 4'd8, 6'b000010);

    // blt is unsupported -> TRAP, no retire
    cyc(BR, 3'd4, 1'b0, 1'b1); st("blt_f", 4'd0, 6'b111000);
    chk("jal_ir", instret, 32'd7);
    cyc(BR, 3'd4, 1'b0, 1'b1); st("blt_d", 4'd1, 6'b000001);
    cyc(BR, 3'd4, 1'b0, 1'b1); st("blt_t", 4'd15, 6'b000000);
    chk("blt_ill", 32'(illegal), 32'd1);
    chk("blt_ir", instret, 32'd7);
    rst_pulse("rst1");

    // unknown opcode -> TRAP by cycle 3, held 20 cycles
    cyc(BAD, 3'd0, 1'b0, 1'b1); st("bad_f", 4'd0, 6'b111000);
    cyc(BAD, 3'd0, 1'b0, 1'b1); st("bad_d", 4'd1, 6'b000001);
    cyc(BAD, 3'd0, 1'b0, 1'b1); st("bad_t", 4'd15, 6'b000000);
    chk("bad_ill", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(BAD, 3'(i), 1'($urandom_range(1)), 1'b1);
      st("trap_hold", 4'd15, 6'b000000);
      chk("trap_ill", 32'(illegal), 32'd1);
    end
    rst_pulse("rst2");

    // async reset in the middle of a MEMWR wait
    cyc(ST, 3'd2, 1'b0, 1'b1); st("ab_f", 4'd0, 6'b111000);
    cyc(ST, 3'd2, 1'b0, 1'b1); st("ab_d", 4'd1, 6'b000001);
    cyc(ST, 3'd2, 1'b0, 1'b0); st("ab_a", 4'd2, 6'b000000);
    cyc(ST, 3'd2, 1'b0, 1'b0); st("ab_w", 4'd5, 6'b000100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_memw", 32'(mem_write), 32'd0);
    st("ab_rst", 4'd0, 6'b000000);
    chk("ab_ir", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(ST, 3'd2, 1'b0, 1'b0); st("ab_post", 4'd0, 6'b001000);
    chk("ab_post_ir", instret, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
